// File: rtl/control_types.sv
// rtl/control_types.sv - shared CPU memory-access control types
package control_types;

  typedef enum logic [2:0] {
    MEM_BYTE,
    MEM_HALF,
    MEM_WORD,
    MEM_BYTE_U,
    MEM_HALF_U
  } mem_op_t;

endpackage

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, status bit positions and FSM states for mmio_uart_tx
package uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; pushes when full and pops when empty are ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are exactly AW bits wide, so they wrap by natural overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module mmio_uart_tx
  import uart_pkg::*;
  import control_types::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        wr_en,
  input  mem_op_t     mem_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t     state;
  logic [7:0]    shift;
  logic [15:0]   bit_cnt;
  logic [15:0]   baud_div;
  logic [2:0]    bit_idx;
  logic          ovf;
  logic          tx_q;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          store;
  logic [1:0]    reg_sel;
  logic          push;
  logic          pop;
  logic          bit_end;
  logic [15:0]   reload;
  logic          unused_bits;

  assign store   = sel && wr_en;
  assign reg_sel = addr[3:2];
  assign push    = store && (reg_sel == REG_TXDATA);
  assign bit_end = (bit_cnt == 16'd0);
  assign reload  = baud_div - 16'd1;
  assign pop     = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

  // Access size and the undecoded address/data bits do not affect this peripheral
  assign unused_bits = ^{mem_ctrl, addr[31:4], addr[1:0], data_in[31:16]};

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(data_in[7:0]),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_div <= DEFAULT_DIV;
      ovf      <= 1'b0;
    end else begin
      if (push && fifo_full) begin
        ovf <= 1'b1;
      end else if (store && (reg_sel == REG_CTRL) && data_in[0]) begin
        ovf <= 1'b0;
      end
      if (store && (reg_sel == REG_BAUDDIV)) begin
        baud_div <= (data_in[15:0] == 16'd0) ? 16'd1 : data_in[15:0];
      end
    end
  end

  // bit_cnt counts down the cycles of the current bit and reloads from
  // baud_div at every boundary, so a divider change applies from the next bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx_q    <= 1'b1;
      shift   <= 8'd0;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift   <= fifo_rdata;
            bit_cnt <= reload;
            tx_q    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= reload;
            bit_idx <= 3'd0;
            tx_q    <= shift[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= reload;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx_q    <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift   <= fifo_rdata;
              bit_cnt <= reload;
              tx_q    <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          tx_q  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign tx  = tx_q;
  assign irq = fifo_empty && (state == IDLE);

  always_comb begin
    data_out = 32'd0;
    if (sel) begin
      case (reg_sel)
        REG_STATUS: begin
          data_out[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
          data_out[STAT_BUSY]           = (state != IDLE);
          data_out[STAT_FULL]           = fifo_full;
          data_out[STAT_EMPTY]          = fifo_empty;
          data_out[STAT_OVF]            = ovf;
        end
        REG_BAUDDIV: data_out[15:0] = baud_div;
        REG_CTRL:    data_out[0]    = ovf;
        default:     data_out       = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;
  import control_types::*;

  localparam int          DEPTH     = 8;
  localparam logic [31:0] BASE      = 32'h4000_0000;
  localparam logic [31:0] A_TXDATA  = BASE + 32'h0;
  localparam logic [31:0] A_STATUS  = BASE + 32'h4;
  localparam logic [31:0] A_BAUDDIV = BASE + 32'h8;
  localparam logic [31:0] A_CTRL    = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        wr_en = 1'b0;
  mem_op_t     mem_ctrl = MEM_WORD;
  logic [31:0] addr = 32'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        tx;
  logic        irq;

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .wr_en   (wr_en),
    .mem_ctrl(mem_ctrl),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .tx      (tx),
    .irq     (irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: queued bytes, plus the line levels still to be driven for the
  // frame in flight, one entry per clock cycle.
  logic [7:0] mq[$];
  bit         wave[$];
  int         m_baud = 868;
  bit         m_ovf = 1'b0;
  bit         live = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit       full_pre;
    bit [7:0] b;
    if (reset) begin
      mq.delete();
      wave.delete();
      m_baud = 868;
      m_ovf  = 1'b0;
      live   = 1'b1;
      return;
    end
    full_pre = (mq.size() == DEPTH);
    if (wave.size() != 0) void'(wave.pop_front());
    if (wave.size() == 0 && mq.size() != 0) begin
      b = mq.pop_front();
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < m_baud; c++) begin
          wave.push_back((k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1]);
        end
      end
    end
    if (sel && wr_en) begin
      case (addr[3:2])
        2'd0: if (full_pre) m_ovf = 1'b1; else mq.push_back(data_in[7:0]);
        2'd2: m_baud = (data_in[15:0] == 16'd0) ? 1 : int'(data_in[15:0]);
        2'd3: if (data_in[0]) m_ovf = 1'b0;
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] m_read();
    logic [31:0] r;
    r = 32'd0;
    if (sel) begin
      case (addr[3:2])
        2'd1: r = {16'd0, 8'(mq.size()), 4'd0, m_ovf, mq.size() == 0,
                   mq.size() == DEPTH, wave.size() != 0};
        2'd2: r = 32'(m_baud);
        2'd3: r = {31'd0, m_ovf};
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (live) begin
      check("model_tx", {31'd0, tx}, {31'd0, (wave.size() != 0) ? wave[0] : 1'b1});
      check("model_irq", {31'd0, irq}, {31'd0, mq.size() == 0 && wave.size() == 0});
      check("model_data_out", data_out, m_read());
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    sel      = 1'b1;
    wr_en    = 1'b1;
    addr     = a;
    data_in  = d;
    mem_ctrl = MEM_WORD;
    step();
    sel   = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [31:0] a);
    sel      = 1'b1;
    wr_en    = 1'b0;
    addr     = a;
    mem_ctrl = MEM_BYTE_U;
    #1;
  endtask

  initial begin
    step(3);
    reset = 1'b0;

    load(A_STATUS);
    check("reset_status", data_out, 32'h0000_0004);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd1);
    load(A_BAUDDIV);
    check("reset_bauddiv", data_out, 32'h0000_0364);
    sel = 1'b0;
    #1;
    check("unselected_zero", data_out, 32'd0);

    // 0x55 at 4 cycles/bit: start, then alternating 1/0 data, then stop
    store(A_BAUDDIV, 32'd4);
    store(A_TXDATA, 32'h0000_0055);
    load(A_STATUS);
    for (int i = 0; i < 40; i++) begin
      step();
      check("frame55_tx", {31'd0, tx}, 32'((i / 4) % 2));
      check("frame55_busy", {31'd0, data_out[0]}, 32'd1);
    end
    step();
    check("frame55_irq_after", {31'd0, irq}, 32'd1);
    check("frame55_status_after", data_out, 32'h0000_0004);

    // Back-to-back frames; second store is misaligned, which is ignored
    store(A_BAUDDIV, 32'd2);
    store(A_TXDATA, 32'h0000_00A5);
    store(A_TXDATA + 32'd2, 32'h0000_003C);
    check("b2b_start", {31'd0, tx}, 32'd0);
    for (int i = 1; i < 40; i++) begin
      step();
      if (i == 18 || i == 19) check("b2b_stop1", {31'd0, tx}, 32'd1);
      if (i == 20 || i == 21) check("b2b_start2", {31'd0, tx}, 32'd0);
    end
    step(3);
    check("b2b_irq_after", {31'd0, irq}, 32'd1);

    // Overflow: ten rapid stores into an 8-deep FIFO while a slow frame runs
    store(A_BAUDDIV, 32'd100);
    for (int k = 0; k < 10; k++) store(A_TXDATA, 32'h10 + 32'(k));
    load(A_STATUS);
    check("ovf_status", data_out, 32'h0000_080B);
    store(A_CTRL, 32'd1);
    load(A_STATUS);
    check("ovf_cleared_status", data_out, 32'h0000_0803);
    load(A_CTRL);
    check("ovf_cleared_ctrl", data_out, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    load(A_STATUS);
    check("flush_status", data_out, 32'h0000_0004);

    // Divider of 0 is stored as 1: 0xFF frame is one low cycle then nine high
    store(A_BAUDDIV, 32'd0);
    load(A_BAUDDIV);
    check("bauddiv_zero", data_out, 32'd1);
    store(A_TXDATA, 32'h0000_00FF);
    load(A_STATUS);
    for (int i = 0; i < 10; i++) begin
      step();
      check("frameff_tx", {31'd0, tx}, (i == 0) ? 32'd0 : 32'd1);
    end
    step();
    check("frameff_irq_after", {31'd0, irq}, 32'd1);

    // Reset during data bit 3 with three bytes still queued
    store(A_BAUDDIV, 32'd4);
    store(A_TXDATA, 32'h12);
    store(A_TXDATA, 32'h34);
    store(A_TXDATA, 32'h56);
    store(A_TXDATA, 32'h78);
    step(15);
    check("midframe_bit3", {31'd0, tx}, 32'd0);
    load(A_STATUS);
    check("midframe_count", {24'd0, data_out[15:8]}, 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_status", data_out, 32'h0000_0004);
    check("rst_mid_irq", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 60; i++) begin
      step();
      check("rst_mid_quiet", {31'd0, tx}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
